// File: rtl/tcp_rwnd_monitor_if.sv
// tcp_rwnd_monitor_if: word stream bundle
// data/ctrl/wr forward, rdy backward.
interface tcp_rwnd_monitor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (
    output data,
    output ctrl,
    output wr,
    input  rdy
  );

  modport slave (
    input  data,
    input  ctrl,
    input  wr,
    output rdy
  );
endinterface

// File: rtl/tcp_rwnd_monitor.sv
// tcp_rwnd_monitor: pass-through stage that counts packets
// and tracks the last/minimum TCP receive window.
module tcp_rwnd_monitor #(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH   = 2,
  parameter int UDP_REG_ADDR_WIDTH  = 23,
  parameter int CPCI_NF2_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH      = 3,
  parameter int unsigned BLOCK_ADDR = 32'h12
) (
  input  logic clk,
  input  logic reset,
  tcp_rwnd_monitor_if.slave  in_if,
  tcp_rwnd_monitor_if.master out_if,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);

  localparam int FW    = DATA_WIDTH + CTRL_WIDTH;
  localparam int TAG_W = UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam logic [TAG_W-1:0] TAG = TAG_W'(BLOCK_ADDR);

  localparam logic [REG_ADDR_WIDTH-1:0] OFF_CLR  = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_PKT  = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_TCP  = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_LAST = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_MIN  = REG_ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    MOD_HDRS,
    PKT_HDR,
    PKT_BODY
  } state_t;

  logic [FW-1:0]         fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            depth;
  logic                  fifo_empty;
  logic                  nearly_full;
  logic                  fifo_wr;
  logic                  xfer;
  logic [FW-1:0]         head;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] word_cnt;
  logic [3:0] word_cnt_nxt;
  logic       is_ip;
  logic       is_ip_nxt;
  logic       is_tcp;
  logic       is_tcp_nxt;
  logic       eop;
  logic       win_upd;
  logic [15:0] win_val;

  logic [31:0] pkt_cnt;
  logic [31:0] tcp_cnt;
  logic [15:0] last_win;
  logic [15:0] min_win;
  logic        clear;

  logic                           reg_hit;
  logic [REG_ADDR_WIDTH-1:0]      reg_off;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rd_val;

  assign fifo_empty  = (depth == 3'd0);
  assign nearly_full = (depth >= 3'd3);
  assign fifo_wr     = in_if.wr && (depth != 3'd4);
  assign head        = fifo_mem[rd_ptr];
  assign head_data   = head[DATA_WIDTH-1:0];
  assign head_ctrl   = head[FW-1:DATA_WIDTH];
  assign xfer        = !reset && !fifo_empty && out_if.rdy;

  assign in_if.rdy   = !nearly_full;
  assign out_if.wr   = xfer;
  assign out_if.data = head_data;
  assign out_if.ctrl = head_ctrl;

  assign win_val = head_data[63:48];

  // Storage array: no reset needed, validity tracked by depth.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= {in_if.ctrl, in_if.data};
    end
  end

  // FIFO pointers and occupancy; reset drops any queued words.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      depth  <= 3'd0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (xfer) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      depth <= depth + {2'b0, fifo_wr} - {2'b0, xfer};
    end
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MOD_HDRS;
      word_cnt <= 4'd1;
      is_ip    <= 1'b0;
      is_tcp   <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      is_ip    <= is_ip_nxt;
      is_tcp   <= is_tcp_nxt;
    end
  end

  // Header walk: classify on words 2/3, take window on word 7.
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    is_ip_nxt    = is_ip;
    is_tcp_nxt   = is_tcp;
    eop          = 1'b0;
    win_upd      = 1'b0;
    if (xfer) begin
      unique case (state)
        MOD_HDRS: begin
          if (head_ctrl == '0) begin
            state_nxt    = PKT_HDR;
            word_cnt_nxt = 4'd2;
          end
        end
        PKT_HDR: begin
          word_cnt_nxt = word_cnt + 4'd1;
          if (word_cnt == 4'd2) begin
            is_ip_nxt = (head_data[31:16] == 16'h0800)
                     && (head_data[15:12] == 4'h4);
          end
          if (word_cnt == 4'd3) begin
            is_tcp_nxt = is_ip && (head_data[7:0] == 8'h06);
          end
          if (word_cnt == 4'd7) begin
            win_upd   = is_tcp;
            state_nxt = PKT_BODY;
          end
          eop = (head_ctrl != '0);
        end
        PKT_BODY: begin
          eop = (head_ctrl != '0);
        end
        default: begin
          state_nxt = MOD_HDRS;
        end
      endcase
      if (eop) begin
        state_nxt    = MOD_HDRS;
        word_cnt_nxt = 4'd1;
        is_ip_nxt    = 1'b0;
        is_tcp_nxt   = 1'b0;
      end
    end
  end

  // Statistics; clear holds them at their idle values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pkt_cnt  <= 32'd0;
      tcp_cnt  <= 32'd0;
      last_win <= 16'd0;
      min_win  <= 16'hFFFF;
    end else begin
      if (eop) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (win_upd) begin
        tcp_cnt  <= tcp_cnt + 32'd1;
        last_win <= win_val;
        if (win_val < min_win) begin
          min_win <= win_val;
        end
      end
    end
  end

  assign reg_off = reg_addr_in[REG_ADDR_WIDTH-1:0];
  assign reg_hit = reg_req_in && !reg_ack_in
                && (reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TAG);

  // Read mux over the block's register map.
  always_comb begin
    rd_val = '0;
    case (reg_off)
      OFF_CLR:  rd_val = CPCI_NF2_DATA_WIDTH'(clear);
      OFF_PKT:  rd_val = CPCI_NF2_DATA_WIDTH'(pkt_cnt);
      OFF_TCP:  rd_val = CPCI_NF2_DATA_WIDTH'(tcp_cnt);
      OFF_LAST: rd_val = CPCI_NF2_DATA_WIDTH'(last_win);
      OFF_MIN:  rd_val = CPCI_NF2_DATA_WIDTH'(min_win);
      default:  rd_val = '0;
    endcase
  end

  // Register ring stage: answer own requests, forward the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      clear           <= 1'b0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      reg_ack_out     <= reg_ack_in || reg_hit;
      reg_data_out    <= reg_data_in;
      if (reg_hit) begin
        if (reg_rd_wr_L_in) begin
          reg_data_out <= rd_val;
        end else if (reg_off == OFF_CLR) begin
          clear <= reg_data_in[0];
        end
      end
    end
  end

endmodule

// File: doc/tcp_rwnd_monitor.md
# tcp_rwnd_monitor

Pass-through statistics stage placed directly downstream of the receive-window modifier in the user data path. It forwards every word unchanged, parses the Ethernet/IPv4/TCP header positions of each packet, and publishes packet count, TCP packet count, last TCP receive window and minimum TCP receive window as hardware registers on the UDP register ring. Software can verify the upstream window rewrite from these registers without capturing traffic.

## Interface
- DATA_WIDTH, 64, data bus width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width
- UDP_REG_SRC_WIDTH, 2, register ring source tag width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_data / in_ctrl / in_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  upstream word, ctrl, write strobe
- in_rdy  out  1  = !input_fifo.nearly_full
- out_data / out_ctrl / out_wr  out  DATA_WIDTH / CTRL_WIDTH / 1  downstream word, ctrl, strobe (combinational from FIFO head)
- out_rdy  in  1  downstream can accept
- reg_req/ack/rd_wr_L/addr/data/src _in  in  ring widths (`UDP_REG_ADDR_WIDTH, `CPCI_NF2_DATA_WIDTH, UDP_REG_SRC_WIDTH)  register ring in
- reg_*_out  out  same widths  register ring out, via generic_regs (TAG `TCP_RWND_MON_BLOCK_ADDR, REG_ADDR_WIDTH `TCP_RWND_MON_REG_ADDR_WIDTH, 1 SW reg, 4 HW regs, 0 counters)

## Operation
- Input: fallthrough_small_fifo, WIDTH DATA+CTRL, MAX_DEPTH_BITS 2. Transfer when !empty && out_rdy: out_wr=1, rd_en=1, out_data/out_ctrl = FIFO head unchanged. No word ever dropped, stalled beyond out_rdy, or modified.
- States: MOD_HDRS, PKT_HDR, PKT_BODY.
  - MOD_HDRS: words with ctrl!=0 pass. First ctrl==0 word transferred -> PKT_HDR, word_cnt=2 (that word is word 1).
  - PKT_HDR: per transferred word, word_cnt++. Word 2: is_ip = data[31:16]==16'h0800 && data[15:12]==4'h4. Word 3: is_tcp = is_ip && data[7:0]==8'h06. Word 7: if is_tcp, capture window = data[63:48]; -> PKT_BODY.
  - PKT_BODY: pass until EOP.
  - In PKT_HDR or PKT_BODY, a transferred word with ctrl!=0 is EOP: pkt_cnt++, -> MOD_HDRS, clear is_ip/is_tcp. EOP on word 7 still counts the window, then returns to MOD_HDRS.
- Window update (word 7, is_tcp): tcp_cnt++, last_win=window, min_win = min(min_win, window).
- Packet ending before word 7: pkt_cnt only, no window update.
- HW regs: 0 pkt_cnt [31:0], 1 tcp_cnt [31:0], 2 {16'h0,last_win}, 3 {16'h0,min_win}. Counters wrap 0xFFFFFFFF -> 0.
- SW reg 0 bit 0 = clear: while 1, pkt_cnt=tcp_cnt=0, last_win=0, min_win=16'hFFFF; clear wins over same-cycle increment. Datapath unaffected by clear.

## Timing
- Reset values: state MOD_HDRS, word_cnt 1, flags 0, pkt_cnt 0, tcp_cnt 0, last_win 0, min_win 16'hFFFF; out_wr 0 while reset high; FIFO emptied.
- Datapath latency: 0 cycles from FIFO head to out; FIFO write-to-head 1 cycle. Throughput 1 word/cycle when out_rdy steady high.
- Stats registers update on the clk edge of the transferring cycle; visible to register reads next cycle.
- out_rdy low: no FIFO read, no state/counter change.
- Reset mid-packet: partial packet discarded from FIFO, not counted; next packet parses from MOD_HDRS.
- in_wr while nearly_full: upstream must honour in_rdy; overflow undefined.

## Test plan
- 1 module hdr + 8-word IPv4/TCP packet, window 0x1234 -> output identical word-for-word, pkt_cnt=1, tcp_cnt=1, last_win=0x1234, min_win=0x1234.
- TCP packets with windows 0x8000, 0x0100, 0x4000 -> last_win=0x4000, min_win=0x0100, tcp_cnt=3.
- ARP (ethertype 0x0806) and IPv4 UDP (proto 0x11) packets -> pkt_cnt=2, tcp_cnt=0, min_win=0xFFFF.
- 5-word runt IPv4/TCP packet (EOP at word 5) -> pkt_cnt=1, tcp_cnt=0, next packet parsed correctly.
- Random out_rdy (50%) on 20 mixed packets -> output stream equals input, counts match scoreboard.
- Set clear bit during EOP transfer -> pkt_cnt reads 0 while set; after clear=0 one TCP packet window 0x0200 -> pkt_cnt=1, min_win=0x0200.
